// File: rtl/intersection_phase_scheduler.sv
// Round-robin green/yellow/all-red phase sequencer for an N-approach intersection.
// All timing is counted in ticks of an internal clk prescaler; lamps decode from registered state.
module intersection_phase_scheduler #(
  parameter int unsigned N_APPR    = 4,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 8,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_APPR-1:0]         req,
  input  logic                      hold,
  output logic [N_APPR-1:0]         green,
  output logic [N_APPR-1:0]         yellow,
  output logic [N_APPR-1:0]         red,
  output logic [$clog2(N_APPR)-1:0] cur_idx,
  output logic [1:0]                phase,
  output logic                      grant
);

  localparam int unsigned IDX_W   = $clog2(N_APPR);
  localparam int unsigned TOP_A   = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
  localparam int unsigned CNT_TOP = (TOP_A > ALLRED_T) ? TOP_A : ALLRED_T;
  localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);
  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W:0]   G_MIN       = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0]   G_MAX       = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0]   G_SAT       = (CNT_W+1)'(MAX_GREEN - 1);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } phase_t;

  phase_t            state, state_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W:0]    g;
  logic [PRE_W-1:0]  presc, presc_nx;
  logic [N_APPR-1:0] others;
  logic [IDX_W-1:0]  scan_idx;
  logic              tick;
  logic              found;
  int unsigned       cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_ALLRED;
      cur_idx <= '0;
      presc   <= '0;
      cnt     <= '0;
      grant   <= 1'b0;
    end else begin
      state   <= state_nx;
      cur_idx <= idx_nx;
      presc   <= presc_nx;
      cnt     <= cnt_nx;
      grant   <= (state == ST_ALLRED) && (state_nx == ST_GREEN);
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = cur_idx;
    cnt_nx   = cnt;
    presc_nx = presc;
    tick     = (presc == PRE_LAST);
    g        = {1'b0, cnt} + (CNT_W+1)'(1);
    others   = req;
    others[cur_idx] = 1'b0;

    // Round-robin scan starting after the current owner; the owner itself is checked last.
    scan_idx = cur_idx;
    found    = 1'b0;
    cand     = 0;
    for (int unsigned k = 1; k <= N_APPR; k++) begin
      cand = 32'(cur_idx) + k;
      if (cand >= N_APPR) cand = cand - N_APPR;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        scan_idx = cand[IDX_W-1:0];
      end
    end

    if (!hold) begin
      // Transitions only happen on a tick, so wrapping the prescaler also clears it on phase change.
      presc_nx = tick ? '0 : presc + PRE_W'(1);
      if (tick) begin
        unique case (state)
          ST_ALLRED: begin
            if (cnt == ALLRED_LAST) begin
              state_nx = ST_GREEN;
              cnt_nx   = '0;
              idx_nx   = scan_idx;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
          ST_GREEN: begin
            if ((g >= G_MIN) && (|others) && (!req[cur_idx] || (g >= G_MAX))) begin
              state_nx = ST_YELLOW;
              cnt_nx   = '0;
            end else begin
              cnt_nx = (g >= G_SAT) ? CNT_SAT : g[CNT_W-1:0];
            end
          end
          ST_YELLOW: begin
            if (cnt == YELLOW_LAST) begin
              state_nx = ST_ALLRED;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
          default: begin
            state_nx = ST_ALLRED;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    if (state == ST_GREEN)  green[cur_idx]  = 1'b1;
    if (state == ST_YELLOW) yellow[cur_idx] = 1'b1;
    red   = ~(green | yellow);
    phase = state;
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: default-timing instance plus a TICK_DIV=3 instance.
module tb_intersection_phase_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req, req3;
  logic       hold, hold3;
  logic [3:0] green, yellow, red;
  logic [3:0] green3, yellow3, red3;
  logic [1:0] cur_idx, cur_idx3;
  logic [1:0] phase, phase3;
  logic       grant, grant3;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned lamp_bad = 0;
  bit          mon_en = 0;
  logic [3:0]  seen;

  localparam logic [1:0] P_ALLRED = 2'd0;
  localparam logic [1:0] P_GREEN  = 2'd1;
  localparam logic [1:0] P_YELLOW = 2'd2;

  intersection_phase_scheduler #(.N_APPR(4), .TICK_DIV(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .hold(hold),
    .green(green), .yellow(yellow), .red(red),
    .cur_idx(cur_idx), .phase(phase), .grant(grant)
  );

  intersection_phase_scheduler #(.N_APPR(4), .TICK_DIV(3)) u_div3 (
    .clk(clk), .reset(reset), .req(req3), .hold(hold3),
    .green(green3), .yellow(yellow3), .red(red3),
    .cur_idx(cur_idx3), .phase(phase3), .grant(grant3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp sanity on both instances: red is the complement, at most one lamp lit in green|yellow.
  always @(negedge clk) begin
    if (mon_en) begin
      if (red != ~(green | yellow) || (green & yellow) != 4'b0 || $countones(green | yellow) > 1)
        lamp_bad <= lamp_bad + 1;
      if (red3 != ~(green3 | yellow3) || (green3 & yellow3) != 4'b0 || $countones(green3 | yellow3) > 1)
        lamp_bad <= lamp_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive cycles spent in phase p, leaving the bench on the first cycle after it.
  task automatic measure(input bit div3, input logic [1:0] p, output int unsigned n);
    n = 0;
    while (((div3 ? phase3 : phase) == p) && n < 500) begin
      n++;
      seen = seen | green;
      step();
    end
  endtask

  // Reset for one edge, release, and land on the first GREEN (grant) cycle.
  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
    step();
  endtask

  int unsigned n;
  int unsigned bad;
  int unsigned total;
  logic [1:0]  exp_idx [3];

  initial begin
    reset = 1'b1; req = 4'b0; hold = 1'b0; req3 = 4'b0; hold3 = 1'b0; seen = 4'b0;
    step();
    step();
    mon_en = 1;
    check("rst_phase", phase, P_ALLRED);
    check("rst_red", red, 4'hF);
    check("rst_idx", cur_idx, 0);
    check("rst_grant", grant, 0);

    // Scenario 1: idle intersection parks green on approach 0
    reset = 1'b0;
    step();
    check("s1_phase", phase, P_GREEN);
    check("s1_grant", grant, 1);
    check("s1_green", green, 4'b0001);
    check("s1_red", red, 4'b1110);
    bad = 0;
    repeat (50) begin
      step();
      if (green != 4'b0001 || red != 4'b1110 || grant) bad++;
    end
    check("s1_hold50", bad, 0);

    // Scenario 2: single other requester ends green at MIN_GREEN
    do_reset();
    check("s2_grant", grant, 1);
    req = 4'b0010;
    measure(0, P_GREEN, n);   check("s2_green0", n, 4);
    check("s2_yel_lamp", yellow, 4'b0001);
    measure(0, P_YELLOW, n);  check("s2_yellow", n, 2);
    check("s2_red_all", red, 4'hF);
    measure(0, P_ALLRED, n);  check("s2_allred", n, 1);
    check("s2_idx", cur_idx, 1);
    check("s2_grant1", grant, 1);
    check("s2_green1", green, 4'b0010);

    // Scenario 4: continue from green on 1 with approaches 1 and 3 requesting
    req = 4'b1010;
    seen = 4'b0;
    exp_idx[0] = 2'd3; exp_idx[1] = 2'd1; exp_idx[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      measure(0, P_GREEN, n);  check($sformatf("s4_green_%0d", i), n, 8);
      measure(0, P_YELLOW, n); check($sformatf("s4_yellow_%0d", i), n, 2);
      measure(0, P_ALLRED, n); check($sformatf("s4_allred_%0d", i), n, 1);
      check($sformatf("s4_idx_%0d", i), cur_idx, exp_idx[i]);
    end
    check("s4_no_starve_02", seen & 4'b0101, 0);

    // Scenario 3 then 5: contested greens run to MAX, second yellow is held 5 cycles
    do_reset();
    req = 4'b0011;
    measure(0, P_GREEN, n);  check("s3_green0", n, 8);
    measure(0, P_YELLOW, n); check("s3_yellow0", n, 2);
    measure(0, P_ALLRED, n); check("s3_allred0", n, 1);
    check("s3_idx1", cur_idx, 1);
    measure(0, P_GREEN, n);  check("s3_green1", n, 8);
    check("s5_in_yellow", phase, P_YELLOW);
    hold = 1'b1;
    total = 0;
    repeat (5) begin
      if (phase == P_YELLOW && yellow == 4'b0010) total++;
      step();
    end
    hold = 1'b0;
    measure(0, P_YELLOW, n); check("s5_hold_yellow", total + n, 7);
    measure(0, P_ALLRED, n); check("s3_allred1", n, 1);
    check("s3_idx0", cur_idx, 0);
    check("s3_grant0", grant, 1);

    // Scenario 6: reset while approach 2 is green
    do_reset();
    req = 4'b0100;
    measure(0, P_GREEN, n);  check("s6_green0", n, 4);
    measure(0, P_YELLOW, n); check("s6_yellow", n, 2);
    measure(0, P_ALLRED, n); check("s6_allred", n, 1);
    check("s6_idx2", cur_idx, 2);
    step();
    step();
    check("s6_green2", green, 4'b0100);
    reset = 1'b1;
    req = 4'b0000;
    step();
    check("s6_rst_phase", phase, P_ALLRED);
    check("s6_rst_idx", cur_idx, 0);
    check("s6_rst_red", red, 4'hF);
    check("s6_rst_grant", grant, 0);
    reset = 1'b0;
    step();
    check("s6_resume_phase", phase, P_GREEN);
    check("s6_resume_grant", grant, 1);
    check("s6_resume_green", green, 4'b0001);

    // TICK_DIV=3 instance: every phase is a whole number of 3-cycle ticks
    reset = 1'b1;
    step();
    reset = 1'b0;
    measure(1, P_ALLRED, n); check("d3_allred_init", n, 3);
    check("d3_grant", grant3, 1);
    check("d3_idx0", cur_idx3, 0);
    req3 = 4'b0010;
    measure(1, P_GREEN, n);  check("d3_green", n, 12);
    measure(1, P_YELLOW, n); check("d3_yellow", n, 6);
    measure(1, P_ALLRED, n); check("d3_allred", n, 3);
    check("d3_idx1", cur_idx3, 1);

    step();
    check("lamp_consistency", lamp_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
